// File: rtl/can_bit_timing.sv
// CAN bit timing unit: prescaler, SYNC/TSEG1/TSEG2 sequencer, hard sync and SJW-limited resync.
// Optional build macro CAN_BTU_TRIPLE_SAMPLE_EN selects 3-sample majority voting of rx.
module can_bit_timing #(
  parameter int unsigned BRP_W   = 6,
  parameter int unsigned TSEG1_W = 4,
  parameter int unsigned TSEG2_W = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BRP_W-1:0]   brp_i,
  input  logic [TSEG1_W-1:0] tseg1_i,
  input  logic [TSEG2_W-1:0] tseg2_i,
  input  logic [1:0]         sjw_i,
  input  logic               hard_sync_i,
  input  logic               resync_en_i,
  input  logic               rx_i,
  output logic               tq_o,
  output logic               sample_o,
  output logic               tx_pt_o,
  output logic               bit_clk_o,
  output logic               rx_bit_o
);

  localparam int unsigned SJW_W = 2;
  localparam int unsigned CNT_W = TSEG1_W + 1;
  localparam int unsigned ADJ_W = SJW_W + 1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TSEG1 = 2'd1,
    ST_TSEG2 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [BRP_W-1:0]   brp_cnt_q, brp_cnt_d;
  logic [CNT_W-1:0]   tq_cnt_q, tq_cnt_d;
  logic [ADJ_W-1:0]   ext_q, ext_d;
  logic [ADJ_W-1:0]   shr_q, shr_d;
  logic               rx_prev_q, rx_prev_d;
  logic               resync_done_q, resync_done_d;
  logic [BRP_W-1:0]   brp_s_q, brp_s_d;
  logic [TSEG1_W-1:0] ts1_s_q, ts1_s_d;
  logic [TSEG2_W-1:0] ts2_s_q, ts2_s_d;
  logic [SJW_W-1:0]   sjw_s_q, sjw_s_d;
  logic               tq_q, tq_d;
  logic               sample_q, sample_d;
  logic               tx_pt_q, tx_pt_d;
  logic               bit_clk_q, bit_clk_d;
  logic               rx_bit_q, rx_bit_d;

  logic rx_fall;
  logic hard_sync;
  logic tq_en;
  logic restart;
  logic latch_cfg;
  logic samp_val;

`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
  // Two earlier TSEG1 quantum samples; the third vote is rx_i at the sample point.
  logic [1:0] samp_q, samp_d;
  assign samp_val = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_i) | (samp_q[0] & rx_i);
`else
  assign samp_val = rx_i;
`endif

  // Segment sequencing first, then edge handling applied to the post-advance position.
  always_comb begin
    state_d       = state_q;
    brp_cnt_d     = brp_cnt_q;
    tq_cnt_d      = tq_cnt_q;
    ext_d         = ext_q;
    shr_d         = shr_q;
    resync_done_d = resync_done_q;
    brp_s_d       = brp_s_q;
    ts1_s_d       = ts1_s_q;
    ts2_s_d       = ts2_s_q;
    sjw_s_d       = sjw_s_q;
    sample_d      = 1'b0;
    tx_pt_d       = 1'b0;
    bit_clk_d     = bit_clk_q;
    rx_bit_d      = rx_bit_q;
    restart       = 1'b0;
    latch_cfg     = 1'b0;
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
    samp_d        = samp_q;
`endif

    rx_prev_d = rx_i;
    rx_fall   = rx_prev_q & ~rx_i;
    hard_sync = hard_sync_i & rx_fall;
    tq_en     = (brp_cnt_q == brp_s_q);
    tq_d      = tq_en;
    brp_cnt_d = tq_en ? '0 : brp_cnt_q + BRP_W'(1);

    case (state_q)
      ST_SYNC: begin
        if (tq_en) begin
          state_d  = ST_TSEG1;
          tq_cnt_d = '0;
        end
      end
      ST_TSEG1: begin
        if (tq_en) begin
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
          samp_d = {samp_q[0], rx_i};
`endif
          if (tq_cnt_q >= CNT_W'(ts1_s_q) + CNT_W'(ext_q)) begin
            state_d       = ST_TSEG2;
            tq_cnt_d      = '0;
            sample_d      = 1'b1;
            bit_clk_d     = 1'b0;
            rx_bit_d      = samp_val;
            resync_done_d = 1'b0;
          end else begin
            tq_cnt_d = tq_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_TSEG2: begin
        if (tq_en) begin
          if (tq_cnt_q + CNT_W'(shr_q) >= CNT_W'(ts2_s_q)) begin
            state_d   = ST_SYNC;
            tq_cnt_d  = '0;
            tx_pt_d   = 1'b1;
            bit_clk_d = 1'b1;
            ext_d     = '0;
            shr_d     = '0;
            latch_cfg = 1'b1;
          end else begin
            tq_cnt_d = tq_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_SYNC;
    endcase

    if (hard_sync) begin
      // Hard sync cancels any strobe of this clock and restarts the SYNC quantum.
      restart       = 1'b1;
      sample_d      = 1'b0;
      tx_pt_d       = 1'b0;
      rx_bit_d      = rx_bit_q;
      resync_done_d = resync_done_q;
    end else if (resync_en_i && rx_fall && !resync_done_d) begin
      case (state_d)
        ST_TSEG1: begin
          resync_done_d = 1'b1;
          ext_d = (tq_cnt_d <= CNT_W'(sjw_s_q)) ? ADJ_W'(tq_cnt_d) + ADJ_W'(1)
                                                : ADJ_W'(sjw_s_q) + ADJ_W'(1);
        end
        ST_TSEG2: begin
          resync_done_d = 1'b1;
          // Phase error ts2+1-c within SJW: treat the edge as a new SYNC.
          if (CNT_W'(ts2_s_q) <= tq_cnt_d + CNT_W'(sjw_s_q)) begin
            restart = 1'b1;
          end else begin
            shr_d = ADJ_W'(sjw_s_q) + ADJ_W'(1);
          end
        end
        default: ;
      endcase
    end

    if (restart) begin
      state_d   = ST_SYNC;
      brp_cnt_d = '0;
      tq_cnt_d  = '0;
      ext_d     = '0;
      shr_d     = '0;
      bit_clk_d = 1'b1;
      latch_cfg = 1'b1;
    end

    if (latch_cfg) begin
      brp_s_d = brp_i;
      ts1_s_d = tseg1_i;
      ts2_s_d = tseg2_i;
      sjw_s_d = sjw_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= ST_SYNC;
      brp_cnt_q     <= '0;
      tq_cnt_q      <= '0;
      ext_q         <= '0;
      shr_q         <= '0;
      rx_prev_q     <= 1'b1;
      resync_done_q <= 1'b0;
      brp_s_q       <= brp_i;
      ts1_s_q       <= tseg1_i;
      ts2_s_q       <= tseg2_i;
      sjw_s_q       <= sjw_i;
      tq_q          <= 1'b0;
      sample_q      <= 1'b0;
      tx_pt_q       <= 1'b0;
      bit_clk_q     <= 1'b1;
      rx_bit_q      <= 1'b1;
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
      samp_q        <= 2'b11;
`endif
    end else begin
      state_q       <= state_d;
      brp_cnt_q     <= brp_cnt_d;
      tq_cnt_q      <= tq_cnt_d;
      ext_q         <= ext_d;
      shr_q         <= shr_d;
      rx_prev_q     <= rx_prev_d;
      resync_done_q <= resync_done_d;
      brp_s_q       <= brp_s_d;
      ts1_s_q       <= ts1_s_d;
      ts2_s_q       <= ts2_s_d;
      sjw_s_q       <= sjw_s_d;
      tq_q          <= tq_d;
      sample_q      <= sample_d;
      tx_pt_q       <= tx_pt_d;
      bit_clk_q     <= bit_clk_d;
      rx_bit_q      <= rx_bit_d;
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
      samp_q        <= samp_d;
`endif
    end
  end

  assign tq_o      = tq_q;
  assign sample_o  = sample_q;
  assign tx_pt_o   = tx_pt_q;
  assign bit_clk_o = bit_clk_q;
  assign rx_bit_o  = rx_bit_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Bench for can_bit_timing: directed timing scenarios plus randomized rx/sync traffic
// compared each clock against a bit-position model (clocks elapsed since SYNC start).
module tb_can_bit_timing;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] brp_i = 6'd4;
  logic [3:0] tseg1_i = 4'd5;
  logic [2:0] tseg2_i = 3'd2;
  logic [1:0] sjw_i = 2'd0;
  logic       hard_sync_i = 1'b0;
  logic       resync_en_i = 1'b0;
  logic       rx_i = 1'b1;
  logic       tq_o, sample_o, tx_pt_o, bit_clk_o, rx_bit_o;

  can_bit_timing dut (
    .clk_i(clk_i), .rst_i(rst_i), .brp_i(brp_i), .tseg1_i(tseg1_i), .tseg2_i(tseg2_i),
    .sjw_i(sjw_i), .hard_sync_i(hard_sync_i), .resync_en_i(resync_en_i), .rx_i(rx_i),
    .tq_o(tq_o), .sample_o(sample_o), .tx_pt_o(tx_pt_o), .bit_clk_o(bit_clk_o),
    .rx_bit_o(rx_bit_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit hs_v = 1'b0, rsen_v = 1'b0, rx_v = 1'b1;

  int tx_q[$];
  int smp_q[$];
  bit smpv_q[$];
  int tq_q[$];
  bit bclk_log[$];

  // Reference model: position in clocks since the current SYNC quantum began.
  int m_pos, m_ext, m_shr;
  int c_brp, c_ts1, c_ts2, c_sjw;
  bit m_rd, m_rxp, m_rxb, m_h1, m_h0;
  logic [4:0] m_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void latch_cfg();
    c_brp = int'(brp_i);
    c_ts1 = int'(tseg1_i);
    c_ts2 = int'(tseg2_i);
    c_sjw = int'(sjw_i);
  endfunction

  function automatic int seg1_end();
    return (c_brp + 1) * (c_ts1 + 2 + m_ext);
  endfunction

  function automatic void model_eval(input bit r, input bit hs, input bit rsen, input bit rx);
    int tq, s1, be, idx, c, e;
    bit tq_en, edg, s_ev, tx_ev, rxb_old, rd_old, sv;
    if (!r) begin
      m_pos = 0; m_ext = 0; m_shr = 0; m_rd = 1'b0; m_rxp = 1'b1;
      m_rxb = 1'b1; m_h1 = 1'b1; m_h0 = 1'b1;
      latch_cfg();
      m_exp = 5'b00011;
      return;
    end
    tq = c_brp + 1;
    s1 = seg1_end();
    be = s1 + tq * (c_ts2 + 1 - m_shr);
    tq_en = ((m_pos % tq) == tq - 1);
    edg = m_rxp && !rx;
    m_rxp = rx;
    rxb_old = m_rxb; rd_old = m_rd; s_ev = 1'b0; tx_ev = 1'b0;
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
    sv = (int'(m_h1) + int'(m_h0) + int'(rx)) >= 2;
`else
    sv = rx;
`endif
    if (tq_en && m_pos >= tq && m_pos < s1) begin
      m_h1 = m_h0; m_h0 = rx;
    end
    m_pos++;
    if (m_pos == s1) begin
      s_ev = 1'b1; m_rxb = sv; m_rd = 1'b0;
    end
    if (m_pos == be) begin
      m_pos = 0; tx_ev = 1'b1; m_ext = 0; m_shr = 0; latch_cfg();
    end
    if (hs && edg) begin
      m_pos = 0; m_ext = 0; m_shr = 0; latch_cfg();
      s_ev = 1'b0; tx_ev = 1'b0; m_rxb = rxb_old; m_rd = rd_old;
    end else if (rsen && edg && !m_rd) begin
      tq = c_brp + 1;
      s1 = seg1_end();
      idx = m_pos / tq;
      if (idx >= 1) begin
        m_rd = 1'b1;
        if (m_pos < s1) begin
          c = idx - 1;
          m_ext = (c + 1 < c_sjw + 1) ? c + 1 : c_sjw + 1;
        end else begin
          c = idx - (c_ts1 + 2 + m_ext);
          e = c_ts2 + 1 - c;
          if (e <= c_sjw + 1) begin
            m_pos = 0; m_ext = 0; m_shr = 0; latch_cfg();
          end else begin
            m_shr = c_sjw + 1;
          end
        end
      end
    end
    m_exp = {tq_en, s_ev, tx_ev, (m_pos < seg1_end()), m_rxb};
  endfunction

  task automatic tick(input bit r);
    @(negedge clk_i);
    rst_i = r; hard_sync_i = hs_v; resync_en_i = rsen_v; rx_i = rx_v;
    model_eval(r, hs_v, rsen_v, rx_v);
    @(posedge clk_i);
    #1;
    cyc++;
    check("outs", 32'({tq_o, sample_o, tx_pt_o, bit_clk_o, rx_bit_o}), 32'(m_exp));
    if (tx_pt_o) tx_q.push_back(cyc);
    if (sample_o) begin smp_q.push_back(cyc); smpv_q.push_back(rx_bit_o); end
    if (tq_o) tq_q.push_back(cyc);
    bclk_log.push_back(bit_clk_o);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  task automatic wait_tx(output int t);
    int n0;
    n0 = tx_q.size();
    for (int i = 0; i < 400 && tx_q.size() == n0; i++) tick(1'b1);
    check("wait_tx", 32'(tx_q.size() > n0), 32'd1);
    t = (tx_q.size() > n0) ? tx_q[tx_q.size()-1] : cyc;
  endtask

  function automatic int idx_after(input int q[$], input int x);
    foreach (q[i]) if (q[i] > x) return i;
    return -1;
  endfunction

  function automatic int delta_after(input int q[$], input int x);
    int i;
    i = idx_after(q, x);
    return (i < 0) ? -1 : q[i] - x;
  endfunction

  function automatic int smp_val_after(input int x);
    int i;
    i = idx_after(smp_q, x);
    return (i < 0) ? 2 : int'(smpv_q[i]);
  endfunction

  initial begin
    int t, t2, e, r, hi, exp6;
    // T1: nominal bit, rx idle
    tick(1'b0); tick(1'b0);
    check("rst", 32'({tq_o, sample_o, tx_pt_o, bit_clk_o, rx_bit_o}), 32'h03);
    run(130);
    check("t1_ntx", 32'(tx_q.size() >= 2), 32'd1);
    if (tx_q.size() >= 2) begin
      check("t1_period", 32'(tx_q[1] - tx_q[0]), 32'd50);
      check("t1_sample", 32'(delta_after(smp_q, tx_q[0])), 32'd35);
      hi = 0;
      for (int c = tx_q[0]; c < tx_q[1]; c++) hi += int'(bclk_log[c-1]);
      check("t1_bclk_hi", 32'(hi), 32'd35);
    end
    check("t1_tq", 32'((tq_q.size() >= 2) ? tq_q[1] - tq_q[0] : -1), 32'd5);

    // T2: one-clock reset in TSEG1
    wait_tx(t);
    run(15);
    tick(1'b0);
    r = cyc;
    check("t2_rst", 32'({tq_o, sample_o, tx_pt_o, bit_clk_o, rx_bit_o}), 32'h03);
    run(60);
    check("t2_tx", 32'(delta_after(tx_q, r)), 32'd50);

    // T3: hard sync on edge in TSEG2
    hs_v = 1'b1;
    wait_tx(t);
    run(39);
    rx_v = 1'b0; tick(1'b1); e = cyc;
    run(40);
    check("t3_sample", 32'(delta_after(smp_q, e)), 32'd35);
    check("t3_rxbit", 32'(smp_val_after(e)), 32'd0);
    hs_v = 1'b0; rx_v = 1'b1; run(3);

    // T4: sjw=0, edge at TSEG1 tq_cnt=3, second edge ignored
    rsen_v = 1'b1;
    wait_tx(t);
    run(21);
    rx_v = 1'b0; tick(1'b1);
    rx_v = 1'b1; run(4);
    rx_v = 1'b0; tick(1'b1);
    rx_v = 1'b1;
    wait_tx(t2);
    check("t4_bit", 32'(t2 - t), 32'd55);

    // T5: sjw=1, late edge restarts the bit; early TSEG2 edge shortens it
    sjw_i = 2'd1;
    wait_tx(t);
    run(45);
    rx_v = 1'b0; tick(1'b1); e = cyc;
    run(4);
    rx_v = 1'b1; run(31);
    rx_v = 1'b0; tick(1'b1);
    wait_tx(t2);
    check("t5_sample", 32'(delta_after(smp_q, e)), 32'd35);
    check("t5_bit", 32'(t2 - e), 32'd40);

    // T6: one-tq dominant glitch at the sample point
    rx_v = 1'b1; rsen_v = 1'b0; sjw_i = 2'd0;
    wait_tx(t);
    wait_tx(t);
    run(30);
    rx_v = 1'b0; run(5);
    rx_v = 1'b1; run(5);
`ifdef CAN_BTU_TRIPLE_SAMPLE_EN
    exp6 = 1;
`else
    exp6 = 0;
`endif
    check("t6_rxbit", 32'(smp_val_after(t)), 32'(exp6));

    // Randomized traffic with config changes, hard syncs and resyncs
    for (int ep = 0; ep < 12; ep++) begin
      sjw_i   = 2'($urandom_range(0, 3));
      tseg2_i = 3'($urandom_range(int'(sjw_i), 7));
      tseg1_i = 4'($urandom_range(2, 9));
      brp_i   = 6'($urandom_range(1, 7));
      rx_v = 1'b1; hs_v = 1'b0;
      tick(1'b0); tick(1'b0);
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 15) == 0) rx_v = ~rx_v;
        hs_v   = ($urandom_range(0, 7) == 0);
        rsen_v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) == 0) begin
          sjw_i   = 2'($urandom_range(0, 3));
          tseg2_i = 3'($urandom_range(int'(sjw_i), 7));
          tseg1_i = 4'($urandom_range(2, 9));
          brp_i   = 6'($urandom_range(1, 7));
        end
        tick(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
